// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline boundary registers: payload
// layouts, widths, field offsets and the stage occupancy encoding.
package pipe_pkg;

    // Occupancy encoding reported on pipe_stage_hs.count
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // IF/ID payload: {pc, instr}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;
    localparam int IFID_W         = $bits(ifid_t);   // 64
    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_PC_LSB    = 32;

    // ID/EX payload: {pc, rs1v, rs2v, imm, rd, alu_op, regwrite, memread, memwrite}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } idex_t;
    localparam int IDEX_W            = $bits(idex_t); // 140
    localparam int IDEX_MEMWRITE_LSB = 0;
    localparam int IDEX_MEMREAD_LSB  = 1;
    localparam int IDEX_REGWRITE_LSB = 2;
    localparam int IDEX_ALUOP_LSB    = 3;
    localparam int IDEX_RD_LSB       = 7;
    localparam int IDEX_IMM_LSB      = 12;
    localparam int IDEX_RS2V_LSB     = 44;
    localparam int IDEX_RS1V_LSB     = 76;
    localparam int IDEX_PC_LSB       = 108;

    // EX/MEM payload: {alu_res, st_data, rd, regwrite, memread, memwrite}
    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] st_data;
        logic [4:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
    } exmem_t;
    localparam int EXMEM_W            = $bits(exmem_t); // 72
    localparam int EXMEM_MEMWRITE_LSB = 0;
    localparam int EXMEM_MEMREAD_LSB  = 1;
    localparam int EXMEM_REGWRITE_LSB = 2;
    localparam int EXMEM_RD_LSB       = 3;
    localparam int EXMEM_STDATA_LSB   = 8;
    localparam int EXMEM_ALURES_LSB   = 40;

    // MEM/WB payload: {wb_data, rd, regwrite}; an all-zero bubble means no writeback
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        regwrite;
    } memwb_t;
    localparam int MEMWB_W            = $bits(memwb_t); // 38
    localparam int MEMWB_REGWRITE_LSB = 0;
    localparam int MEMWB_RD_LSB       = 1;
    localparam int MEMWB_WBDATA_LSB   = 6;

    // Occupancy from the two entry valid bits (skid is only ever full behind a full main)
    function automatic logic [1:0] cnt_enc(input logic main_v, input logic skid_v);
        if (main_v && skid_v) return CNT_FULL;
        if (main_v || skid_v) return CNT_ONE;
        return CNT_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus W-bit payload, with load and clear.
// Clear optionally zeroes the payload so idle entries read as all-zero.
module pipe_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic         clr,
    input  logic         zclr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    // Entry register: reset > clear > load; payload holds when nothing happens
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (clr) begin
            vld <= 1'b0;
            if (zclr) q <= '0;
        end else if (ld) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline boundary register with valid/ready handshake, flush and an
// optional skid entry. With SKID=1, in_ready comes straight from the skid
// valid flop (gated only by reset/flush), breaking the ready path upstream.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int W         = 64,
    parameter int SKID      = 1,
    parameter int ZERO_IDLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic         main_v;
    logic [W-1:0] main_q;
    logic [W-1:0] main_d;
    logic         main_ld;
    logic         main_clr;
    logic         main_zclr;
    logic         in_fire;
    logic         out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v & out_ready;
    assign out_valid = main_v;
    // Every path that empties main zeroes it when ZERO_IDLE is set, so the
    // payload register itself is the idle-zero output.
    assign out_data  = main_q;
    // Flush always zeroes; a normal pop zeroes only in ZERO_IDLE mode
    assign main_zclr = flush | (ZERO_IDLE != 0);

    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .reset (reset),
        .ld    (main_ld),
        .clr   (main_clr),
        .zclr  (main_zclr),
        .d     (main_d),
        .vld   (main_v),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        logic         skid_v;
        logic [W-1:0] skid_q;
        logic         skid_ld;
        logic         skid_clr;

        // Registered ready: only the skid flop decides, reset/flush block intake
        assign in_ready = ~skid_v & ~reset & ~flush;

        // Main refills from skid on a pop, otherwise from input when it is free.
        // in_fire is impossible while skid is full, so the two never collide.
        assign main_d   = skid_v ? skid_q : in_data;
        assign main_ld  = (out_fire & skid_v) | (in_fire & (~main_v | out_fire));
        assign main_clr = flush | (out_fire & ~main_ld);

        // Skid catches the input only when main is full and stalled
        assign skid_ld  = in_fire & main_v & ~out_fire;
        assign skid_clr = flush | (out_fire & skid_v);

        pipe_slot #(.W(W)) u_skid (
            .clk   (clk),
            .reset (reset),
            .ld    (skid_ld),
            .clr   (skid_clr),
            .zclr  (1'b1),
            .d     (in_data),
            .vld   (skid_v),
            .q     (skid_q)
        );

        assign count = cnt_enc(main_v, skid_v);
    end else begin : g_single
        // Combinational ready: accept when empty or when the entry leaves now
        assign in_ready = (~main_v | out_ready) & ~reset & ~flush;
        assign main_d   = in_data;
        assign main_ld  = in_fire;
        assign main_clr = flush | (out_fire & ~in_fire);
        assign count    = cnt_enc(main_v, 1'b0);
    end

endmodule
